// File: rtl/dff_bank_pkg.sv
// ---------------------------------------------------------------------------
// dff_bank_pkg
// Shared types and helpers for the dff_bank_arbiter slice.
//   state_e : arbiter sequencing state (IDLE / LOCKED)
//   clog2   : ceiling log2, used for address, owner and lock-counter widths
// ---------------------------------------------------------------------------
package dff_bank_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Ceiling log2 for elaboration-time width calculation.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set bit of eligible_i
// searching ptr_i, ptr_i+1, ... modulo N_REQ.
//   eligible_i : candidate requesters
//   ptr_i      : search start index
//   win_oh_o   : one-hot winner (zero when no candidate)
//   win_idx_o  : winner index (zero when no candidate)
//   any_o      : at least one candidate present
// ---------------------------------------------------------------------------
module rr_pick
    import dff_bank_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [IW-1:0]    win_idx_o,
    output logic             any_o
);

    logic [IW-1:0] cand;
    logic          found;

    // NOTE: every output and temporary gets a default before the loop so the
    // block stays purely combinational and no latch is inferred.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IW'((int'(ptr_i) + i) % N_REQ);
            if (!found && eligible_i[cand]) begin
                found           = 1'b1;
                win_idx_o       = cand;
                win_oh_o[cand]  = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// dff_bank_arbiter
// Round-robin arbiter and sequencer in front of a DEPTH x WIDTH register
// bank. One access (read or write) per clock edge; a requester holding
// lock may take up to LOCK_MAX consecutive accesses before being forced out.
//   clk    : clock, all state updates on posedge
//   rst    : synchronous active-low reset
//   req    : per-requester access request (level)
//   lock   : per-requester lock request, qualified by req
//   we     : per-requester 1 = write, 0 = read
//   addr   : packed per-requester addresses, slice i = requester i
//   wdata  : packed per-requester write data
//   gnt    : one-hot registered grant, one cycle per completed access
//   rvalid : high with gnt when the granted access was a read
//   rdata  : read data of the most recent granted read
// ---------------------------------------------------------------------------
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ-1:0]       we,
    input  logic [N_REQ*clog2(DEPTH)-1:0] addr,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic                   rvalid,
    output logic [WIDTH-1:0]       rdata
);

    localparam int AW = clog2(DEPTH);
    localparam int IW = clog2(N_REQ);
    localparam int CW = clog2(LOCK_MAX + 1);

    // Registered state
    state_e           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] bank_q [DEPTH];

    // Unpacked views of the per-requester buses
    logic [AW-1:0]    addr_arr  [N_REQ];
    logic [WIDTH-1:0] wdata_arr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr[i]  = addr[i*AW +: AW];
            wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
        end
    end

    // Arbitration
    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] win_oh;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    logic             keep_lock;

    assign owner_oh = N_REQ'(1) << owner_q;
    // In IDLE the previous winner sits out one arbitration; on a forced
    // release from LOCKED the owner is the one masked (it was also gnt_q).
    assign mask     = (state_q == LOCKED) ? owner_oh : gnt_q;
    assign eligible = req & ~mask;

    assign keep_lock = (state_q == LOCKED) && req[owner_q] && lock[owner_q]
                       && (cnt_q < CW'(LOCK_MAX));

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .win_oh_o   (win_oh),
        .win_idx_o  (win_idx),
        .any_o      (win_any)
    );

    // Access selection and next state
    logic             acc_en;
    logic [IW-1:0]    acc_sel;
    logic             acc_we;
    logic [AW-1:0]    acc_addr;
    logic             wr_en;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        acc_en  = 1'b0;
        acc_sel = owner_q;

        if (keep_lock) begin
            acc_en  = 1'b1;
            acc_sel = owner_q;
            gnt_d   = owner_oh;
            cnt_d   = cnt_q + CW'(1);
        end else begin
            // Covers both plain IDLE and a forced release from LOCKED: the
            // release edge arbitrates normally, so there is no dead cycle.
            state_d = IDLE;
            cnt_d   = '0;
            if (win_any) begin
                acc_en  = 1'b1;
                acc_sel = win_idx;
                gnt_d   = win_oh;
                ptr_d   = IW'((int'(win_idx) + 1) % N_REQ);
                if (lock[win_idx]) begin
                    state_d = LOCKED;
                    owner_d = win_idx;
                    cnt_d   = CW'(1);
                end
            end
        end
    end

    assign acc_we   = we[acc_sel];
    assign acc_addr = addr_arr[acc_sel];
    assign wr_en    = acc_en & acc_we;
    assign rvalid_d = acc_en & ~acc_we;
    assign rdata_d  = (acc_en && !acc_we) ? bank_q[acc_addr] : rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            // NOTE: the bank is a flop array that must read back zero after
            // reset, so it is cleared here unlike a RAM-style memory.
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            if (wr_en) begin
                bank_q[acc_addr] <= wdata_arr[acc_sel];
            end
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule
